// File: rtl/credit_controller.sv
// Slot-machine front end: button sync/debounce, saturating credit balance, start_stop issue.
// Latency: press acted on DEBOUNCE_CYCLES+2 edges after btn_raw is first sampled high; coin/payout visible next cycle.
// Backpressure: none; coin is always accepted, and a press that cannot be served in the current state is discarded.
module credit_controller #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int START_CREDITS   = 10,
   parameter int BET             = 1,
   parameter int PAYOUT          = 5,
   parameter int MAX_CREDITS     = 99
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_raw,
   input  logic       coin,
   input  logic       spin_done,
   input  logic       win_flag,
   output logic       start_stop,
   output logic [6:0] credits,
   output logic       busy,
   output logic       no_credit,
   output logic       win_pulse
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, SPIN, WAIT} state_t;

   state_t        state;
   logic          sync_a;
   logic          sync_b;
   logic          btn_deb;
   logic          btn_deb_q;
   logic [CW-1:0] db_cnt;
   logic          press;
   logic          take_bet;
   logic          pay;
   logic [7:0]    sum;
   logic [6:0]    credits_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_a    <= 1'b0;
         sync_b    <= 1'b0;
         btn_deb   <= 1'b0;
         btn_deb_q <= 1'b0;
         db_cnt    <= '0;
      end else begin
         sync_a    <= btn_raw;
         sync_b    <= sync_a;
         btn_deb_q <= btn_deb;
         // Any agreement restarts the count, so only an unbroken run of the new level flips btn_deb.
         if (sync_b == btn_deb) begin
            db_cnt <= '0;
         end else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            btn_deb <= sync_b;
            db_cnt  <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   assign press     = btn_deb & ~btn_deb_q;
   assign no_credit = ({1'b0, credits} < 8'(BET));
   assign busy      = (state != IDLE);

   always_comb begin
      take_bet    = (state == IDLE) && press && !no_credit;
      pay         = (state == WAIT) && spin_done && win_flag;
      sum         = {1'b0, credits} - (take_bet ? 8'(BET) : 8'd0)
                    + {7'd0, coin} + (pay ? 8'(PAYOUT) : 8'd0);
      credits_nxt = (sum > 8'(MAX_CREDITS)) ? 7'(MAX_CREDITS) : sum[6:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         credits    <= 7'(START_CREDITS);
         start_stop <= 1'b0;
         win_pulse  <= 1'b0;
      end else begin
         credits    <= credits_nxt;
         win_pulse  <= pay;
         start_stop <= 1'b0;
         case (state)
            IDLE: if (take_bet) begin
               start_stop <= 1'b1;
               state      <= SPIN;
            end
            SPIN: if (press) begin
               start_stop <= 1'b1;
               state      <= WAIT;
            end
            WAIT: if (spin_done) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
